// File: rtl/cacheline_arbiter.sv
// cacheline_arbiter
//   Shares one burst memory port between the instruction cache and the data
//   cache. A whole line request is granted round-robin. Reads are issued as
//   one command followed by LINE_W/BEAT_W returned beats. Writebacks are
//   streamed as LINE_W/BEAT_W write beats. Each transaction ends with a
//   single-cycle response pulse to the cache that was granted.
//
// Ports
//   clk, rst          clock; asynchronous active-low reset
//   i_addr/i_read     icache line read request (held until i_resp)
//   i_rdata/i_resp    assembled line and completion pulse to icache
//   d_addr/d_read/d_write/d_wdata   dcache read / writeback request
//   d_rdata/d_resp    assembled line and completion pulse to dcache
//   bmem_addr         line-aligned address during command / write beats
//   bmem_read         read command, held until bmem_ready
//   bmem_write        write beat valid; bmem_wdata carries the beat
//   bmem_ready        memory accepts the command or write beat
//   bmem_rdata/bmem_rvalid   returned read beats, in order
module cacheline_arbiter #(
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       i_addr,
    input  logic              i_read,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic [31:0]       d_addr,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic [31:0]       bmem_addr,
    output logic              bmem_read,
    output logic              bmem_write,
    output logic [BEAT_W-1:0] bmem_wdata,
    input  logic              bmem_ready,
    input  logic [BEAT_W-1:0] bmem_rdata,
    input  logic              bmem_rvalid
);

    localparam int                 BEATS     = LINE_W / BEAT_W;
    localparam int                 BEAT_CW   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_CW-1:0] LAST_BEAT = BEAT_CW'(BEATS - 1);
    // Clears the byte-offset bits of a line address.
    localparam logic [31:0]        LINE_MASK = ~32'(LINE_W / 8 - 1);

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        RD_CMD,
        RD_BEATS,
        WR_BEATS,
        RESP
    } state_t;

    state_t              state;
    state_t              state_n;
    logic [BEAT_CW-1:0]  beat;
    // Requester currently / most recently granted; drives the round-robin tie
    // break, the response steering and the stale-request mask.
    logic                last_grant;
    // High only in the IDLE cycle right after RESP.
    logic                mask_vld;

    logic [31:0]         addr_q;
    logic [LINE_W-1:0]   wline;
    logic [LINE_W-1:0]   line_q;
    logic [LINE_W-1:0]   line_n;

    logic                req_i;
    logic                req_d;
    logic                start;
    logic                grant_n;

    // Next-state and grant decision
    always_comb begin
        req_i   = i_read && !(mask_vld && last_grant == REQ_I);
        req_d   = (d_read || d_write) && !(mask_vld && last_grant == REQ_D);
        start   = 1'b0;
        grant_n = last_grant;
        state_n = state;
        line_n  = line_q;
        line_n[int'(beat) * BEAT_W +: BEAT_W] = bmem_rdata;

        case (state)
            IDLE: begin
                if (req_i && req_d) begin
                    start   = 1'b1;
                    grant_n = ~last_grant;
                end else if (req_i) begin
                    start   = 1'b1;
                    grant_n = REQ_I;
                end else if (req_d) begin
                    start   = 1'b1;
                    grant_n = REQ_D;
                end
                if (start) begin
                    state_n = (grant_n == REQ_D && d_write) ? WR_BEATS : RD_CMD;
                end
            end
            RD_CMD: begin
                if (bmem_ready) state_n = RD_BEATS;
            end
            RD_BEATS: begin
                if (bmem_rvalid && beat == LAST_BEAT) state_n = RESP;
            end
            WR_BEATS: begin
                if (bmem_ready && beat == LAST_BEAT) state_n = RESP;
            end
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Control state and returned lines
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            beat       <= '0;
            last_grant <= REQ_D;
            mask_vld   <= 1'b0;
            i_rdata    <= '0;
            d_rdata    <= '0;
        end else begin
            state    <= state_n;
            mask_vld <= (state == RESP);
            if (state == IDLE && start) begin
                last_grant <= grant_n;
                beat       <= '0;
            end
            // The beat counter is exactly wide enough to wrap back to 0 after
            // the last beat, ready for the next transaction.
            if ((state == RD_BEATS && bmem_rvalid) || (state == WR_BEATS && bmem_ready)) begin
                beat <= beat + 1'b1;
            end
            if (state == RD_BEATS && bmem_rvalid && beat == LAST_BEAT) begin
                if (last_grant == REQ_D) begin
                    d_rdata <= line_n;
                end else begin
                    i_rdata <= line_n;
                end
            end
        end
    end

    // Transaction datapath: latched address, writeback line, partial read line
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            addr_q <= ((grant_n == REQ_D) ? d_addr : i_addr) & LINE_MASK;
            if (grant_n == REQ_D && d_write) begin
                wline <= d_wdata;
            end
        end
        if (state == RD_BEATS && bmem_rvalid) begin
            line_q <= line_n;
        end
    end

    // Outputs decoded from state only
    assign bmem_read  = (state == RD_CMD);
    assign bmem_write = (state == WR_BEATS);
    assign bmem_addr  = (bmem_read || bmem_write) ? addr_q : '0;
    assign bmem_wdata = bmem_write ? wline[int'(beat) * BEAT_W +: BEAT_W] : '0;
    assign i_resp     = (state == RESP) && (last_grant == REQ_I);
    assign d_resp     = (state == RESP) && (last_grant == REQ_D);

    // A dcache read and writeback at the same time has no defined meaning.
    a_no_dcache_rd_wr: assert property (@(posedge clk) disable iff (!rst) !(d_read && d_write));

endmodule

// File: tb/tb_cacheline_arbiter.sv
module tb_cacheline_arbiter;

    localparam int LINE_W = 256;
    localparam int BEAT_W = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       i_addr;
    logic              i_read;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    logic [31:0]       d_addr;
    logic              d_read;
    logic              d_write;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    logic [31:0]       bmem_addr;
    logic              bmem_read;
    logic              bmem_write;
    logic [BEAT_W-1:0] bmem_wdata;
    logic              bmem_ready;
    logic [BEAT_W-1:0] bmem_rdata;
    logic              bmem_rvalid;

    cacheline_arbiter #(.LINE_W(LINE_W), .BEAT_W(BEAT_W)) dut (
        .clk(clk), .rst(rst),
        .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
        .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_rdata(bmem_rdata),
        .bmem_rvalid(bmem_rvalid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic              who;   // 0 icache, 1 dcache
        logic              wr;
        logic [31:0]       addr;
        logic [LINE_W-1:0] line;
    } exp_t;
    exp_t sb[$];

    // Memory model state
    bit          salt_en = 1'b0;
    int          rd_left = 0;
    int          rd_k = 0;
    logic [31:0] rd_addr = '0;
    logic [31:0] rd_cmd_addr = '0;
    int          rd_hi_cnt = 0;
    logic [63:0] wr_log[$];
    logic [63:0] stall_vals[$];
    logic [31:0] wr_addr = '0;
    int          wr_last_acc = -1;
    int          stall_beat = -1;
    int          stall_len = 0;
    int          stall_done = 0;
    int          overlap_cnt = 0;

    function automatic logic [63:0] beat_val(input logic [31:0] a, input int k);
        logic [3:0]  nib;
        logic [63:0] salt;
        nib  = 4'(k + 1);
        salt = salt_en ? {a, ~a} : 64'd0;
        return {16{nib}} ^ salt;
    endfunction

    function automatic logic [LINE_W-1:0] line_val(input logic [31:0] a);
        logic [LINE_W-1:0] l;
        for (int k = 0; k < 4; k++) l[64*k +: 64] = beat_val(a, k);
        return l;
    endfunction

    // Burst memory responder, driven on the falling edge
    always @(negedge clk or negedge rst) begin
        if (!rst) begin
            rd_left     = 0;
            rd_k        = 0;
            bmem_rvalid = 1'b0;
            bmem_rdata  = '0;
            bmem_ready  = 1'b1;
        end else begin
            if (rd_left > 0) begin
                bmem_rvalid = 1'b1;
                bmem_rdata  = beat_val(rd_addr, rd_k);
                rd_k++;
                rd_left--;
            end else begin
                bmem_rvalid = 1'b0;
                bmem_rdata  = '0;
            end
            bmem_ready = 1'b1;
            if (bmem_write && wr_log.size() == stall_beat && stall_done < stall_len) begin
                bmem_ready = 1'b0;
                stall_done++;
                stall_vals.push_back(bmem_wdata);
            end
            if (bmem_write && bmem_ready) begin
                if (wr_log.size() == 0) wr_addr = bmem_addr;
                wr_log.push_back(bmem_wdata);
                wr_last_acc = cyc;
            end
            if (bmem_read) begin
                rd_hi_cnt++;
                rd_cmd_addr = bmem_addr;
                if (bmem_ready) begin
                    rd_left = 4;
                    rd_k    = 0;
                    rd_addr = bmem_addr;
                end
            end
            if (i_resp && d_resp) overlap_cnt++;
        end
    end

    task automatic wait_resp(input int limit, output bit got, output bit ir, output bit dr, output int at);
        got = 1'b0; ir = 1'b0; dr = 1'b0; at = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (i_resp || d_resp) begin
                got = 1'b1; ir = i_resp; dr = d_resp; at = cyc;
                break;
            end
        end
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        i_addr = '0; i_read = 1'b0; d_addr = '0; d_read = 1'b0; d_write = 1'b0; d_wdata = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bmem_read, bmem_write, i_resp, d_resp} !== 4'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 0000", {bmem_read, bmem_write, i_resp, d_resp});
        end
        n_checks++;
        if (bmem_addr !== 32'd0 || bmem_wdata !== 64'd0) begin
            n_fail++; $display("FAIL reset_bmem: addr %h wdata %h want 0", bmem_addr, bmem_wdata);
        end
        n_checks++;
        if (i_rdata !== '0 || d_rdata !== '0) begin
            n_fail++; $display("FAIL reset_rdata: i %h d %h want 0", i_rdata, d_rdata);
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bmem_read, bmem_write, i_resp, d_resp} !== 4'b0) begin
            n_fail++; $display("FAIL idle_after_reset: got %b want 0000", {bmem_read, bmem_write, i_resp, d_resp});
        end
    endtask

    task automatic test_single_read();
        exp_t e;
        bit got, ir, dr;
        int at, t0;
        logic [LINE_W-1:0] want;
        want = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        salt_en = 1'b0;
        rd_hi_cnt = 0;
        e.who = 1'b0; e.wr = 1'b0; e.addr = 32'h1234_5660; e.line = want;
        @(negedge clk);
        i_addr = 32'h1234_5678; i_read = 1'b1; t0 = cyc;
        sb.push_back(e);
        wait_resp(20, got, ir, dr, at);
        i_read = 1'b0;
        e = sb.pop_front();
        n_checks++;
        if (!got || ir !== 1'b1 || dr !== 1'b0) begin
            n_fail++; $display("FAIL rd_resp_who: got=%0b i=%0b d=%0b want i=1 d=0", got, ir, dr);
        end
        n_checks++;
        if (at - t0 !== 6) begin
            n_fail++; $display("FAIL rd_latency: got %0d want 6", at - t0);
        end
        n_checks++;
        if (i_rdata !== e.line) begin
            n_fail++; $display("FAIL rd_line: got %h want %h", i_rdata, e.line);
        end
        n_checks++;
        if (rd_cmd_addr !== e.addr || rd_hi_cnt !== 1) begin
            n_fail++; $display("FAIL rd_cmd: addr %h cycles %0d want %h 1", rd_cmd_addr, rd_hi_cnt, e.addr);
        end
        @(negedge clk);
        n_checks++;
        if (i_resp !== 1'b0 || d_resp !== 1'b0) begin
            n_fail++; $display("FAIL rd_resp_width: i=%0b d=%0b want 0 0", i_resp, d_resp);
        end
        n_checks++;
        if (i_rdata !== want) begin
            n_fail++; $display("FAIL rd_line_hold: got %h want %h", i_rdata, want);
        end
        repeat (2) @(negedge clk);
    endtask

    logic [LINE_W-1:0] last_d_line;

    task automatic test_simultaneous();
        exp_t e;
        bit got, ir, dr;
        int at;
        apply_reset();
        salt_en = 1'b1;
        overlap_cnt = 0;
        for (int n = 0; n < 4; n++) begin
            e.who  = n[0];
            e.wr   = 1'b0;
            e.addr = n[0] ? 32'h8000_20C0 : 32'h0000_1040;
            e.line = line_val(e.addr);
            sb.push_back(e);
        end
        i_addr = 32'h0000_1040; d_addr = 32'h8000_20C0;
        i_read = 1'b1; d_read = 1'b1;
        for (int n = 0; n < 4; n++) begin
            wait_resp(30, got, ir, dr, at);
            if (n == 3) begin
                i_read = 1'b0; d_read = 1'b0;
            end
            e = sb.pop_front();
            n_checks++;
            if (!got || dr !== e.who || ir !== !e.who) begin
                n_fail++; $display("FAIL rr_order_%0d: got=%0b i=%0b d=%0b want d=%0b", n, got, ir, dr, e.who);
            end
            n_checks++;
            if ((e.who ? d_rdata : i_rdata) !== e.line) begin
                n_fail++; $display("FAIL rr_line_%0d: got %h want %h", n, e.who ? d_rdata : i_rdata, e.line);
            end
            if (e.who) last_d_line = e.line;
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (overlap_cnt !== 0) begin
            n_fail++; $display("FAIL rr_overlap: got %0d want 0", overlap_cnt);
        end
    endtask

    task automatic test_write_stall();
        exp_t e;
        bit got, ir, dr;
        int at, t0;
        logic [LINE_W-1:0] wl;
        wl = {64'hD4D4_0004_4444_0004, 64'hC3C3_0003_3333_0003,
              64'hB2B2_0002_2222_0002, 64'hA1A1_0001_1111_0001};
        wr_log.delete(); stall_vals.delete();
        stall_beat = 1; stall_len = 2; stall_done = 0;
        e.who = 1'b1; e.wr = 1'b1; e.addr = 32'h0000_ABC0; e.line = wl;
        @(negedge clk);
        d_addr = 32'h0000_ABCD; d_wdata = wl; d_write = 1'b1; t0 = cyc;
        sb.push_back(e);
        wait_resp(30, got, ir, dr, at);
        d_write = 1'b0;
        e = sb.pop_front();
        n_checks++;
        if (!got || dr !== 1'b1 || ir !== 1'b0) begin
            n_fail++; $display("FAIL wr_resp_who: got=%0b i=%0b d=%0b want i=0 d=1", got, ir, dr);
        end
        n_checks++;
        if (wr_log.size() !== 4) begin
            n_fail++; $display("FAIL wr_beat_count: got %0d want 4", wr_log.size());
        end
        for (int k = 0; k < 4; k++) begin
            if (k < wr_log.size()) begin
                n_checks++;
                if (wr_log[k] !== e.line[64*k +: 64]) begin
                    n_fail++; $display("FAIL wr_beat_%0d: got %h want %h", k, wr_log[k], e.line[64*k +: 64]);
                end
            end
        end
        n_checks++;
        if (stall_vals.size() !== 2) begin
            n_fail++; $display("FAIL wr_stall_cycles: got %0d want 2", stall_vals.size());
        end
        for (int k = 0; k < stall_vals.size(); k++) begin
            n_checks++;
            if (stall_vals[k] !== e.line[127:64]) begin
                n_fail++; $display("FAIL wr_stall_hold_%0d: got %h want %h", k, stall_vals[k], e.line[127:64]);
            end
        end
        n_checks++;
        if (at !== wr_last_acc + 1 || at - t0 !== 7) begin
            n_fail++; $display("FAIL wr_resp_time: resp %0d last_acc %0d start %0d want +1 and 7", at, wr_last_acc, t0);
        end
        n_checks++;
        if (wr_addr !== e.addr) begin
            n_fail++; $display("FAIL wr_addr: got %h want %h", wr_addr, e.addr);
        end
        n_checks++;
        if (d_rdata !== last_d_line) begin
            n_fail++; $display("FAIL wr_rdata_kept: got %h want %h", d_rdata, last_d_line);
        end
        stall_beat = -1; stall_len = 0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_stale_mask();
        exp_t e;
        bit got, ir, dr;
        int at, act;
        salt_en = 1'b1;
        // Request held only through the masked cycle: nothing new may start.
        @(negedge clk);
        d_addr = 32'h0000_3000; d_read = 1'b1;
        e.who = 1'b1; e.wr = 1'b0; e.addr = 32'h0000_3000; e.line = line_val(e.addr);
        sb.push_back(e);
        wait_resp(30, got, ir, dr, at);
        e = sb.pop_front();
        n_checks++;
        if (!got || dr !== 1'b1 || d_rdata !== e.line) begin
            n_fail++; $display("FAIL mask_first_rd: got=%0b d=%0b data %h want %h", got, dr, d_rdata, e.line);
        end
        @(negedge clk);
        @(negedge clk);
        act = int'(bmem_read) + int'(bmem_write);
        d_read = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            act += int'(bmem_read) + int'(bmem_write) + int'(i_resp) + int'(d_resp);
        end
        n_checks++;
        if (act !== 0) begin
            n_fail++; $display("FAIL mask_no_restart: got %0d active cycles want 0", act);
        end
        // Request still high after the masked cycle: served on the next grant.
        d_addr = 32'h0000_5A40; d_read = 1'b1;
        e.addr = 32'h0000_5A40; e.line = line_val(e.addr);
        sb.push_back(e);
        wait_resp(30, got, ir, dr, at);
        e = sb.pop_front();
        n_checks++;
        if (!got || dr !== 1'b1 || d_rdata !== e.line) begin
            n_fail++; $display("FAIL mask_second_rd: got=%0b d=%0b data %h want %h", got, dr, d_rdata, e.line);
        end
        e.addr = 32'h0000_5A40; e.line = line_val(e.addr);
        sb.push_back(e);
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (bmem_read !== 1'b0) begin
            n_fail++; $display("FAIL mask_cycle_idle: bmem_read %0b want 0", bmem_read);
        end
        @(negedge clk);
        n_checks++;
        if (bmem_read !== 1'b1 || bmem_addr !== 32'h0000_5A40) begin
            n_fail++; $display("FAIL mask_regrant: bmem_read %0b addr %h want 1 00005a40", bmem_read, bmem_addr);
        end
        // Dropping the request mid-transaction must not abort it.
        d_read = 1'b0;
        wait_resp(30, got, ir, dr, at);
        e = sb.pop_front();
        n_checks++;
        if (!got || dr !== 1'b1 || d_rdata !== e.line) begin
            n_fail++; $display("FAIL drop_completes: got=%0b d=%0b data %h want %h", got, dr, d_rdata, e.line);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid_read();
        exp_t e;
        bit got, ir, dr, seen;
        int at, act;
        salt_en = 1'b1;
        @(negedge clk);
        i_addr = 32'h0000_7700; i_read = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (rd_k == 2) begin
                seen = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!seen) begin
            n_fail++; $display("FAIL rstmid_beats: got %0d beats want 2", rd_k);
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({bmem_read, bmem_write, i_resp, d_resp} !== 4'b0 || bmem_addr !== 32'd0 || bmem_wdata !== 64'd0) begin
            n_fail++; $display("FAIL rstmid_bmem: ctrl %b addr %h wdata %h want 0", {bmem_read, bmem_write, i_resp, d_resp}, bmem_addr, bmem_wdata);
        end
        n_checks++;
        if (i_rdata !== '0 || d_rdata !== '0) begin
            n_fail++; $display("FAIL rstmid_rdata: i %h d %h want 0", i_rdata, d_rdata);
        end
        i_read = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        act = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            act += int'(i_resp) + int'(d_resp) + int'(bmem_read) + int'(bmem_write);
        end
        n_checks++;
        if (act !== 0) begin
            n_fail++; $display("FAIL rstmid_no_resp: got %0d active cycles want 0", act);
        end
        // Tie after reset must go to icache.
        e.who = 1'b0; e.wr = 1'b0; e.addr = 32'h0000_7700; e.line = line_val(e.addr);
        sb.push_back(e);
        e.who = 1'b1; e.addr = 32'h0000_8800; e.line = line_val(e.addr);
        sb.push_back(e);
        d_addr = 32'h0000_8800;
        i_read = 1'b1; d_read = 1'b1;
        for (int n = 0; n < 2; n++) begin
            wait_resp(30, got, ir, dr, at);
            if (ir) i_read = 1'b0;
            if (dr) d_read = 1'b0;
            e = sb.pop_front();
            n_checks++;
            if (!got || dr !== e.who || ir !== !e.who) begin
                n_fail++; $display("FAIL rstmid_order_%0d: got=%0b i=%0b d=%0b want d=%0b", n, got, ir, dr, e.who);
            end
            n_checks++;
            if ((e.who ? d_rdata : i_rdata) !== e.line) begin
                n_fail++; $display("FAIL rstmid_line_%0d: got %h want %h", n, e.who ? d_rdata : i_rdata, e.line);
            end
        end
        i_read = 1'b0; d_read = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_simultaneous();
        test_write_stall();
        test_stale_mask();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
